// File: rtl/mem_xy_reader_pkg.sv
// rtl/mem_xy_reader_pkg.sv - shared state enum, defaults and pair types for mem_xy_reader
// MEM_XY_READER_IDX_EN adds the (i, j) indices to the pair tag.
package mem_xy_reader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int IDX_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Everything stored next to the data words in the pair FIFO.
  typedef struct packed {
    logic             last;
`ifdef MEM_XY_READER_IDX_EN
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
`endif
  } pair_tag_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] x;
    logic [DATA_W_DEF-1:0] y;
    pair_tag_t             tag;
  } pair_t;

endpackage

// File: rtl/mem_xy_reader_if.sv
// rtl/mem_xy_reader_if.sv - memory read port and pair output stream of mem_xy_reader
// MEM_XY_READER_IDX_EN adds out_i/out_j to the stream.
interface mem_xy_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);

  logic              rdX;
  logic              rdY;
  logic [ADDR_W-1:0] addrX;
  logic [ADDR_W-1:0] addrY;
  logic [DATA_W-1:0] dataX;
  logic [DATA_W-1:0] dataY;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_x;
  logic [DATA_W-1:0] out_y;
  logic              out_last;
`ifdef MEM_XY_READER_IDX_EN
  logic [4:0]        out_i;
  logic [4:0]        out_j;
`endif

  modport master (
    output rdX, rdY, addrX, addrY,
    input  dataX, dataY,
    output out_valid, out_x, out_y, out_last,
`ifdef MEM_XY_READER_IDX_EN
    output out_i, out_j,
`endif
    input  out_ready
  );

  modport slave (
    input  rdX, rdY, addrX, addrY,
    output dataX, dataY,
    input  out_valid, out_x, out_y, out_last,
`ifdef MEM_XY_READER_IDX_EN
    input  out_i, out_j,
`endif
    output out_ready
  );

endinterface

// File: rtl/mem_xy_reader_pair_fifo.sv
// rtl/mem_xy_reader_pair_fifo.sv - 2-entry FIFO of pair structs with a registered head (xy_pair_fifo)
module xy_pair_fifo
  import mem_xy_reader_pkg::*;
#(
  parameter type T = pair_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  T           i_data,
  input  logic       i_pop,
  output T           o_head,
  output logic       o_valid,
  output logic [1:0] o_count
);

  T           r_mem0;
  T           r_mem1;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Entry 0 is always the head, so the head leaves straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= i_data;
          else                 r_mem1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_mem0 <= i_data;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_mem0;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/mem_xy_reader.sv
// rtl/mem_xy_reader.sv - sweeps all (X[i], Y[j]) pairs from the operand memories onto a pair stream
// MEM_XY_READER_IDX_EN carries out_i/out_j alongside each pair.
module mem_xy_reader
  import mem_xy_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [4:0]     sizeX_,
  input  logic [4:0]     sizeY_,
  output logic           busy,
  output logic           done,
  mem_xy_reader_if.master bus
);

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    pair_tag_t         tag;
  } pair_w_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_size_x;
  logic [IDX_W-1:0] r_size_y;
  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_j;
  logic             r_inflight;
  pair_tag_t        r_infl_tag;

  logic             w_issue;
  logic             w_final;
  logic             w_row_end;
  logic             w_pop;
  logic             w_head_valid;
  logic [1:0]       w_count;
  pair_tag_t        w_issue_tag;
  pair_w_t          w_push_data;
  pair_w_t          w_head;

  assign w_pop     = w_head_valid && bus.out_ready;
  assign w_row_end = (r_i == r_size_x - 5'd1);
  assign w_final   = w_row_end && (r_j == r_size_y - 5'd1);

  // Counting the slot freed by this cycle's pop keeps the stream bubble-free
  // while still never holding more than two pairs in FIFO plus flight.
  assign w_issue = (r_state == RUN) &&
                   (({1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);

  always_comb begin
    w_issue_tag      = '0;
    w_issue_tag.last = w_final;
`ifdef MEM_XY_READER_IDX_EN
    w_issue_tag.i    = r_i;
    w_issue_tag.j    = r_j;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ((sizeX_ == 5'd0) || (sizeY_ == 5'd0)) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_issue && w_final) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_pop && w_head.tag.last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_size_x   <= '0;
      r_size_y   <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_inflight <= 1'b0;
      r_infl_tag <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (r_state == IDLE && start) begin
        r_size_x <= sizeX_;
        r_size_y <= sizeY_;
        r_i      <= '0;
        r_j      <= '0;
      end else if (w_issue) begin
        r_infl_tag <= w_issue_tag;
        if (w_row_end) begin
          r_i <= '0;
          r_j <= w_final ? '0 : r_j + 5'd1;
        end else begin
          r_i <= r_i + 5'd1;
        end
      end
    end
  end

  assign w_push_data.x   = bus.dataX;
  assign w_push_data.y   = bus.dataY;
  assign w_push_data.tag = r_infl_tag;

  xy_pair_fifo #(
    .T (pair_w_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_count)
  );

  assign bus.rdX       = w_issue;
  assign bus.rdY       = w_issue;
  assign bus.addrX     = ADDR_W'(r_i);
  assign bus.addrY     = ADDR_W'(r_j);
  assign bus.out_valid = w_head_valid;
  assign bus.out_x     = w_head.x;
  assign bus.out_y     = w_head.y;
  assign bus.out_last  = w_head_valid && w_head.tag.last;
`ifdef MEM_XY_READER_IDX_EN
  assign bus.out_i     = w_head.tag.i;
  assign bus.out_j     = w_head.tag.j;
`endif

endmodule

// File: tb/tb_mem_xy_reader.sv
// tb/tb_mem_xy_reader.sv - self-checking bench for mem_xy_reader against a pair-sweep reference model
module tb_mem_xy_reader;

  localparam int DW = 8;
  localparam int AW = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] sizeX_ = '0;
  logic [4:0] sizeY_ = '0;
  logic       busy;
  logic       done;

  mem_xy_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_xy_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sizeX_ (sizeX_),
    .sizeY_ (sizeY_),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cc = 0;
  int t0 = 0;

  logic [DW-1:0] memX [32];
  logic [DW-1:0] memY [32];

  logic [9:0]  exp_addr [$];
  logic [16:0] exp_beat [$];
  int rd_cnt, beat_cnt, done_cnt, done_cyc, busy_cnt, max_occ, first_valid;
  logic c1_busy, c1_rd;

  typedef struct {
    int sx;
    int sy;
    int pct;
    int hold;
    bit restart;
    int exp_beats;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Synchronous memories; garbage when not read so stale captures show up.
  always @(posedge clk) begin
    bus.dataX <= bus.rdX ? memX[bus.addrX] : DW'($urandom);
    bus.dataY <= bus.rdY ? memY[bus.addrY] : DW'($urandom);
  end

  always @(posedge clk) cc <= cc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (cc - t0 == 1) begin
        c1_busy = busy;
        c1_rd   = bus.rdX;
      end
      if (bus.rdX || bus.rdY) begin
        rd_cnt++;
        chk("rd_pair", bus.rdX & bus.rdY, 1);
        chk("read_in_budget", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) chk("read_addr", {bus.addrX, bus.addrY}, exp_addr.pop_front());
      end
      if (bus.out_valid && first_valid < 0) first_valid = cc - t0;
      if (bus.out_valid && bus.out_ready) begin
        beat_cnt++;
        chk("beat_in_budget", exp_beat.size() > 0, 1);
        if (exp_beat.size() > 0) chk("beat", {bus.out_x, bus.out_y, bus.out_last}, exp_beat.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cc - t0;
        chk("busy_low_at_done", busy, 0);
      end
      if (busy) busy_cnt++;
      if (rd_cnt - beat_cnt > max_occ) max_occ = rd_cnt - beat_cnt;
    end
  end

  task automatic chk_reset_outs(input string nm);
    chk(nm, {busy, done, bus.rdX, bus.rdY, bus.out_valid, bus.out_last}, 0);
    chk({nm, "_addr"}, {bus.addrX, bus.addrY}, 0);
    chk({nm, "_data"}, {bus.out_x, bus.out_y}, 0);
  endtask

  // Reference model: j outer, i inner, last on the final pair.
  task automatic begin_sweep(input int sx, input int sy, input logic rdy);
    exp_addr.delete();
    exp_beat.delete();
    for (int j = 0; j < sy; j++)
      for (int i = 0; i < sx; i++) begin
        exp_addr.push_back({i[4:0], j[4:0]});
        exp_beat.push_back({memX[i], memY[j], (i == sx - 1) && (j == sy - 1)});
      end
    rd_cnt = 0; beat_cnt = 0; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; max_occ = 0; first_valid = -1;
    c1_busy = 1'bx; c1_rd = 1'bx;
    bus.out_ready = rdy;
    start  = 1'b1;
    sizeX_ = sx[4:0];
    sizeY_ = sy[4:0];
    t0 = cc;
    @(posedge clk); #1;
    start  = 1'b0;
    sizeX_ = 5'($urandom);
    sizeY_ = 5'($urandom);
  endtask

  task automatic run_sweep(input vec_t v);
    int  n;
    bit  released;
    n = v.sx * v.sy;
    released = (v.hold == 0);
    begin_sweep(v.sx, v.sy, released && ($urandom_range(99) < v.pct));
    for (int k = 1; k < 6000 && done_cnt == 0; k++) begin
      start = v.restart && (k == 4);
      if (start) begin
        sizeX_ = 5'd2;
        sizeY_ = 5'd9;
      end
      if (!released) begin
        if (first_valid >= 0 && (cc - t0) >= first_valid + v.hold) begin
          chk("hold_reads", rd_cnt, 2);
          released = 1'b1;
          bus.out_ready = 1'b1;
        end else begin
          bus.out_ready = 1'b0;
        end
      end else begin
        bus.out_ready = ($urandom_range(99) < v.pct);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (3) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("beats", beat_cnt, v.exp_beats);
    chk("reads", rd_cnt, n);
    chk("done_pulses", done_cnt, 1);
    chk("model_drained", exp_beat.size(), 0);
    chk("occupancy_le2", max_occ <= 2, 1);
    chk("busy_cycle1", c1_busy, n > 0);
    chk("rd_cycle1", c1_rd, n > 0);
    if (v.pct == 100 && v.hold == 0) chk("done_cycle", done_cyc, (n == 0) ? 1 : n + 3);
    if (n == 0) chk("busy_never", busy_cnt, 0);
  endtask

  initial begin
    vec_t vt[10];
    vec_t rv;
    for (int a = 0; a < 32; a++) begin
      memX[a] = DW'($urandom);
      memY[a] = DW'($urandom);
    end
    vt[0] = '{3, 2, 100, 0, 1'b0, 6};
    vt[1] = '{0, 5, 100, 0, 1'b0, 0};
    vt[2] = '{31, 31, 50, 0, 1'b0, 961};
    vt[3] = '{4, 3, 100, 10, 1'b0, 12};
    vt[4] = '{5, 4, 100, 0, 1'b1, 20};
    vt[5] = '{1, 1, 100, 0, 1'b0, 1};
    vt[6] = '{7, 0, 100, 0, 1'b0, 0};
    vt[7] = '{31, 2, 100, 0, 1'b0, 62};
    vt[8] = '{6, 5, 40, 0, 1'b0, 30};
    vt[9] = '{1, 9, 100, 0, 1'b0, 9};

    bus.out_ready = 1'b0;
    rd_cnt = 0; beat_cnt = 0; done_cnt = 0; busy_cnt = 0; max_occ = 0; first_valid = -1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("after_reset");

    for (int t = 0; t < 10; t++) run_sweep(vt[t]);

    for (int r = 0; r < 3; r++) begin
      rv.sx = $urandom_range(31, 1);
      rv.sy = $urandom_range(31, 1);
      rv.pct = $urandom_range(100, 20);
      rv.hold = 0;
      rv.restart = 1'b0;
      rv.exp_beats = rv.sx * rv.sy;
      run_sweep(rv);
    end

    // Abort a 4x4 sweep with reset at beat 4, then rerun it cleanly.
    begin_sweep(4, 4, 1'b1);
    for (int k = 0; k < 200 && beat_cnt < 4; k++) begin
      @(posedge clk); #1;
    end
    chk("abort_at_beat4", beat_cnt, 4);
    rst = 1'b1;
    #1;
    chk_reset_outs("abort_reset");
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_done_low", done, 0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort_no_done", done_cnt, 0);
    chk_reset_outs("abort_idle");
    run_sweep('{4, 4, 100, 0, 1'b0, 16});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
